// File: rtl/elink_trig_wb_reader_if.sv
// Wishbone read channel between the trigger reader (master) and the elink trigger scrubber (slave).
interface elink_trig_wb_reader_if #(
    parameter int NUM_ADDRS = 4
);
    logic [NUM_ADDRS-1:0] o_wb_addr;
    logic                 o_wb_stb;
    logic                 i_wb_stall;
    logic                 i_wb_ack;
    logic [9:0]           i_wb_data;

    modport master (
        output o_wb_addr, o_wb_stb,
        input  i_wb_stall, i_wb_ack, i_wb_data
    );

    modport slave (
        input  o_wb_addr, o_wb_stb,
        output i_wb_stall, i_wb_ack, i_wb_data
    );
endinterface

// File: rtl/elink_trig_wb_reader.sv
// Sweeps Wishbone addresses 0..MAX_ADDR, forwarding each voted trigger word downstream.
// Define ELINK_TRIG_READER_PARITY_EN to add the registered out_parity output.
module elink_trig_wb_reader #(
    parameter int NUM_ADDRS   = 4,
    parameter int MAX_ADDR    = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    elink_trig_wb_reader_if.master wb,
    output logic [9:0]             out_data,
    output logic [NUM_ADDRS-1:0]   out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
`ifdef ELINK_TRIG_READER_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, PUSH, FINISH} state_e;

    localparam logic [NUM_ADDRS-1:0] LAST_ADDR = NUM_ADDRS'(MAX_ADDR);
    localparam logic [3:0]           TMO_LAST  = 4'(ACK_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [NUM_ADDRS-1:0] addr_q, addr_d;
    logic                 stb_q, stb_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [9:0]           data_q, data_d;
    logic [NUM_ADDRS-1:0] oaddr_q, oaddr_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 terr_q, terr_d;
`ifdef ELINK_TRIG_READER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        valid_d = valid_q;
        terr_d  = terr_q;
`ifdef ELINK_TRIG_READER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    addr_d  = '0;
                    stb_d   = 1'b1;
                end
            end
            REQ: begin
                if (!wb.i_wb_stall) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            WAIT_ACK: begin
                if (wb.i_wb_ack) begin
                    data_d  = wb.i_wb_data;
                    oaddr_d = addr_q;
                    valid_d = 1'b1;
                    stb_d   = 1'b0;
                    state_d = PUSH;
`ifdef ELINK_TRIG_READER_PARITY_EN
                    parity_d = ^wb.i_wb_data;
`endif
                end else if (cnt_q == TMO_LAST) begin
                    // Timed-out word passes through PUSH with no valid, giving the stb-low gap.
                    stb_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = PUSH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PUSH: begin
                if (!valid_q || out_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        stb_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                stb_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stb_q    <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            oaddr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
`ifdef ELINK_TRIG_READER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stb_q    <= stb_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            oaddr_q  <= oaddr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
`ifdef ELINK_TRIG_READER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign wb.o_wb_addr = addr_q;
    assign wb.o_wb_stb  = stb_q;
    assign out_data     = data_q;
    assign out_addr     = oaddr_q;
    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_err  = terr_q;
`ifdef ELINK_TRIG_READER_PARITY_EN
    assign out_parity   = parity_q;
`endif

endmodule
